// File: rtl/serial_add_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl_pkg
// Shared definitions for the bit-serial add/subtract controller:
//   WIDTH_DEF            default operand/result width
//   ST_IDLE/ST_RUN/ST_FIN controller state encodings
//   OP_ADD/OP_SUB        operation codes carried on OP
// ---------------------------------------------------------------------------
package serial_add_ctrl_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_FIN  = 2'b10;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl_fa
// One-bit full adder used as the single arithmetic element of the serial
// adder.
//   a_i, b_i  operand bits
//   ci_i      carry in
//   s_o       sum bit
//   co_o      carry out
// ---------------------------------------------------------------------------
module serial_add_ctrl_fa (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   output logic s_o,
   output logic co_o
);

   assign s_o  = a_i ^ b_i ^ ci_i;
   assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial WIDTH-bit adder/subtractor. Operands are captured on an accepted
// START, processed LSB-first through one full adder over WIDTH cycles, and
// the result is presented with a one-cycle DONE pulse.
//   CLK    clock, rising edge
//   RST    asynchronous active-low reset
//   START  request, sampled only while idle
//   OP     0 = A + B, 1 = A - B (captured with START)
//   A, B   operands (captured with START)
//   R      result, held until the next accepted START
//   CO     final carry out (for subtract: 1 = no borrow)
//   V      signed overflow, present only with SERIAL_ADD_OVERFLOW_EN defined
//   BUSY   high while bits are being processed
//   DONE   one-cycle pulse when R/CO/V are valid
// Build option: define SERIAL_ADD_OVERFLOW_EN to add the V output.
// ---------------------------------------------------------------------------
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             OP,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] R,
   output logic             CO,
`ifdef SERIAL_ADD_OVERFLOW_EN
   output logic             V,
`endif
   output logic             BUSY,
   output logic             DONE
);

   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             op_q, op_d;
   logic             co_q, co_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
`ifdef SERIAL_ADD_OVERFLOW_EN
   logic             v_q, v_d;
`endif

   logic fa_b;
   logic fa_s;
   logic fa_co;

   // Subtract is A + ~B + 1: B is inverted bit by bit and the +1 comes from
   // the carry flop being preloaded with OP.
   assign fa_b = b_sh_q[0] ^ (op_q != OP_ADD);

   serial_add_ctrl_fa u_fa (
      .a_i  (a_sh_q[0]),
      .b_i  (fa_b),
      .ci_i (carry_q),
      .s_o  (fa_s),
      .co_o (fa_co)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      op_d    = op_q;
      co_d    = co_q;
      done_d  = 1'b0;
      r_d     = r_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
`ifdef SERIAL_ADD_OVERFLOW_EN
      v_d     = v_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d = ST_RUN;
               a_sh_d  = A;
               b_sh_d  = B;
               op_d    = OP;
               cnt_d   = '0;
               carry_d = (OP == OP_SUB);
            end
         end
         ST_RUN: begin
            // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at R[0].
            r_d     = {fa_s, r_q[WIDTH-1:1]};
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            carry_d = fa_co;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_FIN;
`ifdef SERIAL_ADD_OVERFLOW_EN
               // carry_q is the carry into the MSB on this last bit.
               v_d = carry_q ^ fa_co;
`endif
            end
         end
         ST_FIN: begin
            // Results are registered on leaving FIN, so DONE is seen in the
            // following cycle, when the block is already idle and can take
            // the next START.
            state_d = ST_IDLE;
            co_d    = carry_q;
            done_d  = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         op_q    <= 1'b0;
         co_q    <= 1'b0;
         done_q  <= 1'b0;
         r_q     <= '0;
`ifdef SERIAL_ADD_OVERFLOW_EN
         v_q     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         op_q    <= op_d;
         co_q    <= co_d;
         done_q  <= done_d;
         r_q     <= r_d;
`ifdef SERIAL_ADD_OVERFLOW_EN
         v_q     <= v_d;
`endif
      end
   end

   // Operand shift registers carry only data; the state machine decides
   // when their contents matter.
   always_ff @(posedge CLK) begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
   end

   assign R    = r_q;
   assign CO   = co_q;
   assign BUSY = (state_q == ST_RUN);
   assign DONE = done_q;
`ifdef SERIAL_ADD_OVERFLOW_EN
   assign V    = v_q;
`endif

endmodule
